divider_ctrl: RTL and testbench

Runtime controller for the shared programmable clock divider. Up to NUM_REQ requesters ask for a division ratio, and a round-robin arbiter picks one. The chosen ratio is loaded only at a divider period boundary, so clk_out never produces a runt pulse. The block sits between the configuration masters and the divided-clock consumers, and replaces the fixed-CNT_MAX divider where the ratio must change at run time.

---
 rtl/divider_pkg.sv | 18 +
 rtl/divider_core.sv | 52 +++++
 rtl/divider_ctrl.sv | 145 ++++++++++++++
 tb/tb_divider_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the run-time programmable clock divider.
// Holds the controller state encoding, the minimum legal ratio and the high-phase length rule.
package divider_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_ARB      = 2'd1,
        ST_WAIT_BND = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    // Odd ratios spend the extra cycle in the high phase.
    function automatic int unsigned half_of(input int unsigned div);
        return (div + 1) >> 1;
    endfunction

endpackage

// File: rtl/divider_core.sv
// Period counter and registered clk_out/clk_en; outputs lag the counter by one edge.
// No backpressure: runs every cycle, load_i restarts the period at cnt = 0.
module divider_core
    import divider_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] div_active_i,
    input  logic             load_i,
    output logic             last_o,
    output logic             clk_out_o,
    output logic             clk_en_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] half;
    logic             clk_out_q;
    logic             clk_out_d;
    logic             clk_en_q;
    logic             clk_en_d;

    assign half   = DIV_W'(half_of(32'(div_active_i)));
    assign last_o = (cnt_q == div_active_i - DIV_W'(1));

    always_comb begin
        cnt_d     = cnt_q + DIV_W'(1);
        clk_out_d = (cnt_q < half);
        clk_en_d  = (cnt_q == '0);
        if (last_o || load_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            clk_en_q  <= clk_en_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign clk_en_o  = clk_en_q;

endmodule

// File: rtl/divider_ctrl.sv
// Round-robin arbitration of divider ratio requests; a new ratio is applied only at a period boundary.
// Ack 2 cycles after request for reject/same-ratio, else at the next boundary; requesters hold valid until ack.
module divider_ctrl
    import divider_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic                       sys_clock,
    input  logic                       sys_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DIV_W-1:0]   req_div,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       req_err,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic [DIV_W-1:0]           div_active,
    output logic                       busy,
    output logic                       clk_out,
    output logic                       clk_en
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [DIV_W-1:0]   div_active_q, div_active_d;
    logic [DIV_W-1:0]   div_next_q, div_next_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic               req_err_q, req_err_d;

    logic [NUM_REQ-1:0] vld_eff;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   win_inc;
    logic [DIV_W-1:0]   win_div;
    logic               last;
    logic               load;

    // A requester may still show valid in its ack cycle; don't serve it twice.
    assign vld_eff = req_valid & ~req_ack_q;

    always_comb begin
        win  = rr_ptr_q;
        cand = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (vld_eff[cand]) begin
                win = cand;
            end
        end
    end

    assign win_inc = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
    assign win_div = req_div[int'(win) * DIV_W +: DIV_W];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        win_d        = win_q;
        div_active_d = div_active_q;
        div_next_d   = div_next_q;
        req_ack_d    = '0;
        req_err_d    = 1'b0;
        load         = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (|vld_eff) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                state_d = ST_RUN;
                if (|vld_eff) begin
                    rr_ptr_d = win_inc;
                    win_d    = win;
                    if (win_div < DIV_W'(MIN_DIV)) begin
                        req_ack_d[win] = 1'b1;
                        req_err_d      = 1'b1;
                    end else if (win_div == div_active_q) begin
                        req_ack_d[win] = 1'b1;
                        owner_d        = win;
                    end else begin
                        div_next_d = win_div;
                        state_d    = ST_WAIT_BND;
                    end
                end
            end
            ST_WAIT_BND: begin
                if (last) begin
                    div_active_d     = div_next_q;
                    owner_d          = win_q;
                    req_ack_d[win_q] = 1'b1;
                    load             = 1'b1;
                    state_d          = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge sys_clock or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= ST_RUN;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            win_q        <= '0;
            div_active_q <= DIV_W'(DEFAULT_DIV);
            div_next_q   <= DIV_W'(DEFAULT_DIV);
            req_ack_q    <= '0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            win_q        <= win_d;
            div_active_q <= div_active_d;
            div_next_q   <= div_next_d;
            req_ack_q    <= req_ack_d;
            req_err_q    <= req_err_d;
        end
    end

    divider_core #(
        .DIV_W(DIV_W)
    ) u_core (
        .clk_i       (sys_clock),
        .rst_i       (sys_rst),
        .div_active_i(div_active_q),
        .load_i      (load),
        .last_o      (last),
        .clk_out_o   (clk_out),
        .clk_en_o    (clk_en)
    );

    assign req_ack    = req_ack_q;
    assign req_err    = req_err_q;
    assign owner      = owner_q;
    assign div_active = div_active_q;
    assign busy       = (state_q != ST_RUN);

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed and randomized bench for divider_ctrl against a period-level reference model.
module tb_divider_ctrl;

    localparam int NUM_REQ     = 4;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 5;

    logic                       sys_clock = 1'b0;
    logic                       sys_rst   = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ*DIV_W-1:0]   req_div   = '0;
    logic [NUM_REQ-1:0]         req_ack;
    logic                       req_err;
    logic [$clog2(NUM_REQ)-1:0] owner;
    logic [DIV_W-1:0]           div_active;
    logic                       busy;
    logic                       clk_out;
    logic                       clk_en;

    divider_ctrl #(
        .NUM_REQ    (NUM_REQ),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .sys_clock (sys_clock),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_div   (req_div),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .owner     (owner),
        .div_active(div_active),
        .busy      (busy),
        .clk_out   (clk_out),
        .clk_en    (clk_en)
    );

    always #5 sys_clock = ~sys_clock;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current output period plus request bookkeeping.
    int                 m_div, m_pos, m_ptr, m_owner, m_win, m_next;
    bit                 m_arb_pending, m_waiting;
    logic [NUM_REQ-1:0] m_prev_ack;
    logic [NUM_REQ-1:0] e_ack;
    logic               e_err, e_out, e_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div         = DEFAULT_DIV;
        m_pos         = 0;
        m_ptr         = 0;
        m_owner       = 0;
        m_win         = 0;
        m_next        = DEFAULT_DIV;
        m_arb_pending = 1'b0;
        m_waiting     = 1'b0;
        m_prev_ack    = '0;
        e_ack         = '0;
        e_err         = 1'b0;
        e_out         = 1'b0;
        e_en          = 1'b0;
    endtask

    task automatic check_all();
        chk("clk_out", 32'(clk_out), 32'(e_out));
        chk("clk_en", 32'(clk_en), 32'(e_en));
        chk("req_ack", 32'(req_ack), 32'(e_ack));
        chk("req_err", 32'(req_err), 32'(e_err));
        chk("busy", 32'(busy), 32'(m_arb_pending || m_waiting));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("div_active", 32'(div_active), 32'(m_div));
    endtask

    function automatic int ratio_of(input int i);
        return int'(req_div[i*DIV_W +: DIV_W]);
    endfunction

    task automatic tick();
        logic [NUM_REQ-1:0] v;
        int w, d;
        bit sw;
        @(posedge sys_clock);
        v     = req_valid & ~m_prev_ack;
        e_ack = '0;
        e_err = 1'b0;
        sw    = 1'b0;
        e_en  = (m_pos == 0);
        e_out = (m_pos < (m_div + 1) / 2);
        if (m_waiting) begin
            if (m_pos == m_div - 1) begin
                e_ack[m_win] = 1'b1;
                m_owner      = m_win;
                m_waiting    = 1'b0;
                sw           = 1'b1;
            end
        end else if (m_arb_pending) begin
            m_arb_pending = 1'b0;
            if (v != '0) begin
                w = m_ptr;
                while (!v[w]) w = (w + 1) % NUM_REQ;
                m_ptr = (w + 1) % NUM_REQ;
                d = ratio_of(w);
                if (d < 2) begin
                    e_ack[w] = 1'b1;
                    e_err    = 1'b1;
                end else if (d == m_div) begin
                    e_ack[w] = 1'b1;
                    m_owner  = w;
                end else begin
                    m_next    = d;
                    m_win     = w;
                    m_waiting = 1'b1;
                end
            end
        end else if (v != '0) begin
            m_arb_pending = 1'b1;
        end
        if (sw) begin
            m_div = m_next;
            m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % m_div;
        end
        m_prev_ack = e_ack;
        @(negedge sys_clock);
        check_all();
        req_valid = req_valid & ~req_ack;
    endtask

    task automatic raise(input int i, input int d);
        req_div[i*DIV_W +: DIV_W] = DIV_W'(d);
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_ack(output int idx, output int lat, output bit err);
        bit seen;
        idx  = -1;
        lat  = 0;
        err  = 1'b0;
        seen = 1'b0;
        for (int t = 1; t <= 40 && !seen; t++) begin
            tick();
            if (req_ack != '0) begin
                seen = 1'b1;
                lat  = t;
                err  = req_err;
                for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) idx = i;
            end
        end
        checks++;
        assert (seen === 1'b1) else begin
            errors++;
            $error("FAIL ack_timeout: observed no req_ack within 40 cycles, expected one");
        end
    endtask

    initial begin
        int idx, lat;
        bit err;

        model_reset();
        #1 sys_rst = 1'b1;
        repeat (2) @(negedge sys_clock);
        check_all();
        sys_rst = 1'b0;

        // Free run at the default ratio: 1,1,1,0,0 with clk_en every 5.
        tick();
        chk("first_out", 32'(clk_out), 32'd1);
        chk("first_en", 32'(clk_en), 32'd1);
        repeat (11) tick();

        // Same-ratio request: acked 2 cycles later, no reload.
        raise(3, 5);
        wait_ack(idx, lat, err);
        chk("same_idx", 32'(idx), 32'd3);
        chk("same_lat", 32'(lat), 32'd2);
        chk("same_err", 32'(err), 32'd0);
        repeat (3) tick();

        // Switch to 8 mid-period.
        raise(2, 8);
        wait_ack(idx, lat, err);
        chk("sw_idx", 32'(idx), 32'd2);
        chk("sw_owner", 32'(owner), 32'd2);
        chk("sw_div", 32'(div_active), 32'd8);
        tick();
        chk("sw_first_en", 32'(clk_en), 32'd1);
        repeat (16) tick();

        // Same ratio again moves the rotation pointer back to 0.
        raise(3, 8);
        wait_ack(idx, lat, err);
        chk("same2_lat", 32'(lat), 32'd2);

        // Simultaneous requests served in rotation order.
        raise(0, 4);
        raise(1, 6);
        raise(3, 3);
        wait_ack(idx, lat, err);
        chk("rr_first", 32'(idx), 32'd0);
        wait_ack(idx, lat, err);
        chk("rr_second", 32'(idx), 32'd1);
        wait_ack(idx, lat, err);
        chk("rr_third", 32'(idx), 32'd3);
        chk("rr_div", 32'(div_active), 32'd3);
        repeat (9) tick();

        // Illegal ratio rejected.
        raise(1, 1);
        wait_ack(idx, lat, err);
        chk("rej_idx", 32'(idx), 32'd1);
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_lat", 32'(lat), 32'd2);
        chk("rej_div", 32'(div_active), 32'd3);
        repeat (4) tick();

        // Reset while waiting for a boundary; the request is served again afterwards.
        raise(2, 7);
        for (int t = 0; t < 10 && !m_waiting; t++) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        sys_rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge sys_clock);
        check_all();
        sys_rst = 1'b0;
        chk("rst_div", 32'(div_active), 32'(DEFAULT_DIV));
        wait_ack(idx, lat, err);
        chk("rst_reserve_idx", 32'(idx), 32'd2);
        chk("rst_reserve_div", 32'(div_active), 32'd7);

        // Random requests from all requesters.
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && !req_ack[i] && $urandom_range(0, 15) == 0) begin
                    raise(i, int'($urandom_range(0, 12)));
                end
            end
        end
        repeat (100) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
